// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_meter
// Description : Receive-side PWM duty meter for the R/G/B channels. Each
//               asynchronous pin is synchronised and its on-time counted
//               over a free-running window of PWM_INTERVAL clocks. The three
//               counts, plus a per-channel "level changed" flag, are
//               presented through a valid/ready handshake.
// Ports       : clk                   - system clock
//               rst_n                 - synchronous active-low reset
//               pwm_r/pwm_g/pwm_b     - asynchronous PWM pins
//               duty_r/duty_g/duty_b  - on-clock counts of the last window
//               edges                 - {b,g,r}: level change seen in window
//               valid / ready         - result handshake
//               overrun               - sticky: result overwritten unconsumed
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int          DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_r,
    input  logic          pwm_g,
    input  logic          pwm_b,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    edges,
    output logic          valid,
    input  logic          ready,
    output logic          overrun
);

    localparam int                 c_WIN_W    = $clog2(PWM_INTERVAL);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(PWM_INTERVAL - 1);

    // Channel index 0 = R, 1 = G, 2 = B throughout.
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_prev;
    logic [2:0]          r_edge_acc;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [2:0][DW-1:0]  r_acc;
    logic                r_primed;

    logic [2:0]          w_on;
    logic [2:0]          w_chg;
    logic [2:0]          w_edges_new;
    logic [2:0][DW-1:0]  w_sum;
    logic                w_win_end;

    assign w_on        = r_sync2 ^ {3{ACTIVE_LOW}};
    assign w_chg       = r_sync2 ^ r_prev;
    // A change detected on the final window cycle still belongs to this window.
    assign w_edges_new = r_edge_acc | w_chg;
    assign w_win_end   = (r_win_cnt == c_WIN_LAST);

    // Running on-count including the current sample; the window sum can
    // never exceed PWM_INTERVAL, which DW is sized to hold.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 3; i++) begin
            w_sum[i] = r_acc[i] + {{(DW-1){1'b0}}, w_on[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_edge_acc <= '0;
            r_win_cnt  <= '0;
            r_acc      <= '0;
            r_primed   <= 1'b0;
            duty_r     <= '0;
            duty_g     <= '0;
            duty_b     <= '0;
            edges      <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_sync1 <= {pwm_b, pwm_g, pwm_r};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_win_end) begin
                r_win_cnt  <= '0;
                r_acc      <= '0;
                r_edge_acc <= '0;
                // First window after reset only warms up the synchroniser
                // and prev sample; its result is dropped.
                r_primed   <= 1'b1;
            end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_acc      <= w_sum;
                r_edge_acc <= w_edges_new;
            end

            if (w_win_end && r_primed) begin
                duty_r <= w_sum[0];
                duty_g <= w_sum[1];
                duty_b <= w_sum[2];
                edges  <= w_edges_new;
                valid  <= 1'b1;
                // A transfer on this same cycle consumes the old result, so
                // only an unaccepted result counts as lost.
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_meter
// Description : Self-checking bench for pwm_duty_meter. One instance runs
//               with ACTIVE_LOW=1 (main checks), a second with ACTIVE_LOW=0
//               sees a near-100% G waveform. Expected window results are
//               queued when a waveform is set up and popped at each output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

    localparam int c_PER = 1200;

    typedef logic [35:0] res_t; // {duty_r, duty_g, duty_b, edges}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    int unsigned tick = 0;
    int          phase = 0;
    int          low_len = 300;

    logic        pwm_r, pwm_g, pwm_b, g_ah;
    logic [10:0] duty_r, duty_g, duty_b;
    logic [2:0]  edges;
    logic        valid, overrun;
    logic [10:0] duty_r_ah, duty_g_ah, duty_b_ah;
    logic [2:0]  edges_ah;
    logic        valid_ah, overrun_ah;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    // R low for low_len of every period, G high, B low; G for the
    // active-high instance is low for a single clock per period.
    assign pwm_r = (((tick + phase) % c_PER) < low_len) ? 1'b0 : 1'b1;
    assign pwm_g = 1'b1;
    assign pwm_b = 1'b0;
    assign g_ah  = ((tick % c_PER) == 5) ? 1'b0 : 1'b1;

    pwm_duty_meter #(.PWM_INTERVAL(c_PER), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .edges(edges),
        .valid(valid), .ready(ready), .overrun(overrun)
    );

    pwm_duty_meter #(.PWM_INTERVAL(c_PER), .ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst_n(rst_n), .pwm_r(pwm_r), .pwm_g(g_ah), .pwm_b(pwm_b),
        .duty_r(duty_r_ah), .duty_g(duty_g_ah), .duty_b(duty_b_ah), .edges(edges_ah),
        .valid(valid_ah), .ready(1'b1), .overrun(overrun_ah)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            assert (dut.r_acc[i] <= 11'd1200)
                else $error("FAIL acc_bound ch%0d: got %0d limit 1200", i, dut.r_acc[i]);
        end
    end

    function automatic res_t mk(input int r, input int g, input int b, input logic [2:0] e);
        return {11'(r), 11'(g), 11'(b), e};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({duty_r, duty_g, duty_b} !== 33'd0) begin
            errors++;
            $display("FAIL reset_duty: got %0d/%0d/%0d expected 0/0/0", duty_r, duty_g, duty_b);
        end
        checks++;
        if ({edges, valid, overrun} !== 5'd0) begin
            errors++;
            $display("FAIL reset_flags: got edges=%b valid=%b overrun=%b expected 0", edges, valid, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({duty_r, duty_g, duty_b, edges, valid, overrun} !== 38'd0) begin
            errors++;
            $display("FAIL reset_release: got valid=%b overrun=%b duty_r=%0d expected all 0", valid, overrun, duty_r);
        end
    endtask

    task automatic test_basic();
        int   cyc;
        bit   ok;
        res_t e;
        low_len = 300; phase = 0; ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(300, 0, 1200, 3'b001));
        do_reset();
        for (int w = 0; w < 5; w++) begin
            wait_valid(2600, cyc, ok);
            checks++;
            if (!ok || cyc != ((w == 0) ? 2400 : 1200)) begin
                errors++;
                $display("FAIL basic_latency w%0d: got %0d cycles (ok=%b) expected %0d", w, cyc, ok, (w == 0) ? 2400 : 1200);
            end
            e = exp_q.pop_front();
            checks++;
            if ({duty_r, duty_g, duty_b, edges} !== e) begin
                errors++;
                $display("FAIL basic_data w%0d: got r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                         w, duty_r, duty_g, duty_b, edges, e[35:25], e[24:14], e[13:3], e[2:0]);
            end
        end
    endtask

    task automatic test_phase_sweep();
        int   cyc;
        bit   ok;
        res_t e;
        int   phases [6] = '{1, 299, 300, 600, 901, 1199};
        ready = 1'b1;
        foreach (phases[p]) begin
            phase = phases[p];
            exp_q.push_back(mk(300, 0, 1200, 3'b001));
            do_reset();
            wait_valid(2600, cyc, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {duty_r, duty_g, duty_b, edges} !== e) begin
                errors++;
                $display("FAIL phase_%0d: got ok=%b r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                         phase, ok, duty_r, duty_g, duty_b, edges, e[35:25], e[24:14], e[13:3], e[2:0]);
            end
        end
        phase = 0;
    endtask

    task automatic test_backpressure();
        int          cyc, ovr_k, stay_bad, chg_bad, ovr_drop;
        bit          ok;
        res_t        e;
        logic [10:0] prev_r;
        @(negedge clk);
        ready = 1'b0;
        wait_valid(1300, cyc, ok);
        checks++;
        if (!ok || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got valid_ok=%b overrun=%b expected 1/0", ok, overrun);
        end
        low_len = 600;
        exp_q.push_back(mk(600, 0, 1200, 3'b001));
        prev_r = duty_r; ovr_k = -1; stay_bad = 0; chg_bad = 0; ovr_drop = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (!valid) stay_bad++;
            if (duty_r !== prev_r && (k % c_PER) != 0) chg_bad++;
            prev_r = duty_r;
            if (overrun && ovr_k < 0) ovr_k = k;
            if (ovr_k >= 0 && !overrun) ovr_drop++;
        end
        checks++;
        if (stay_bad != 0) begin
            errors++;
            $display("FAIL bp_valid_hold: got %0d cycles low expected 0", stay_bad);
        end
        checks++;
        if (chg_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d mid-window changes expected 0", chg_bad);
        end
        checks++;
        if (ovr_k != 1200 || ovr_drop != 0) begin
            errors++;
            $display("FAIL bp_overrun: got rise at %0d drops %0d expected 1200/0", ovr_k, ovr_drop);
        end
        e = exp_q.pop_front();
        checks++;
        if ({duty_r, duty_g, duty_b, edges} !== e) begin
            errors++;
            $display("FAIL bp_data: got r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                     duty_r, duty_g, duty_b, edges, e[35:25], e[24:14], e[13:3], e[2:0]);
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_after: got valid=%b overrun=%b expected 0/1", valid, overrun);
        end
        low_len = 300;
    endtask

    task automatic test_simultaneous();
        int   cyc;
        bit   ok;
        res_t e;
        low_len = 300; ready = 1'b0;
        do_reset();
        wait_valid(2600, cyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sim_first: got no valid in %0d cycles expected 2400", cyc);
        end
        low_len = 600;
        exp_q.push_back(mk(600, 0, 1200, 3'b001));
        for (int k = 1; k <= 2400; k++) begin
            @(negedge clk);
            if (k == 600 || k == 2399) ready = 1'b1;
            if (k == 601) ready = 1'b0;
            if (k == 2400) begin
                ready = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (valid !== 1'b1 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL sim_flags: got valid=%b overrun=%b expected 1/0", valid, overrun);
                end
                checks++;
                if ({duty_r, duty_g, duty_b, edges} !== e) begin
                    errors++;
                    $display("FAIL sim_data: got r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                             duty_r, duty_g, duty_b, edges, e[35:25], e[24:14], e[13:3], e[2:0]);
                end
            end
        end
        low_len = 300;
    endtask

    task automatic test_reset_mid();
        int   cyc;
        bit   ok;
        res_t e;
        low_len = 300; ready = 1'b0;
        do_reset();
        wait_valid(2600, cyc, ok);
        repeat (1800) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got valid=%b overrun=%b expected 1/1", valid, overrun);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({duty_r, duty_g, duty_b, edges, valid, overrun} !== 38'd0) begin
            errors++;
            $display("FAIL mid_clear: got r=%0d e=%b valid=%b overrun=%b expected all 0", duty_r, edges, valid, overrun);
        end
        rst_n = 1'b1;
        ready = 1'b1;
        exp_q.push_back(mk(300, 0, 1200, 3'b001));
        wait_valid(2600, cyc, ok);
        checks++;
        if (!ok || cyc != 2400) begin
            errors++;
            $display("FAIL mid_latency: got %0d cycles (ok=%b) expected 2400", cyc, ok);
        end
        e = exp_q.pop_front();
        checks++;
        if ({duty_r, duty_g, duty_b, edges} !== e) begin
            errors++;
            $display("FAIL mid_data: got r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                     duty_r, duty_g, duty_b, edges, e[35:25], e[24:14], e[13:3], e[2:0]);
        end
    endtask

    task automatic test_active_high();
        int   cyc;
        res_t e;
        low_len = 300;
        for (int w = 0; w < 2; w++) exp_q.push_back(mk(900, 1199, 0, 3'b011));
        for (int w = 0; w < 2; w++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!valid_ah && cyc < 1300);
            e = exp_q.pop_front();
            checks++;
            if (!valid_ah || {duty_r_ah, duty_g_ah, duty_b_ah, edges_ah} !== e) begin
                errors++;
                $display("FAIL ah_w%0d: got valid=%b r=%0d g=%0d b=%0d e=%b expected r=%0d g=%0d b=%0d e=%b",
                         w, valid_ah, duty_r_ah, duty_g_ah, duty_b_ah, edges_ah,
                         e[35:25], e[24:14], e[13:3], e[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase_sweep();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_active_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
